// File: rtl/idli_uart_m.sv
// idli 8N1 UART: FIFO-buffered transmitter, single-entry receive holding register.
// Optional IDLI_UART_LOOPBACK_EN feeds the registered TX bit into the RX synchroniser.
module idli_uart_m #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 4
) (
  input  logic       i_uart_gck,
  input  logic       i_uart_rst,
  input  logic [7:0] i_uart_tx_data,
  input  logic       i_uart_tx_vld,
  output logic       o_uart_tx_rdy,
  output logic [7:0] o_uart_rx_data,
  output logic       o_uart_rx_vld,
  input  logic       i_uart_rx_rdy,
  output logic       o_uart_rx_ovf,
  output logic       o_uart_rx_ferr,
  input  logic       i_uart_rx,
  output logic       o_uart_tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(TX_DEPTH);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic [7:0]    mem_q [TX_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [7:0]    fifo_head;

  state_e        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;

  logic          rx_src;
  logic          rx_s1_q, rx_s1_d;
  logic          rx_s2_q, rx_s2_d;
  state_e        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_vld_q, rx_vld_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW])
                   && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = i_uart_tx_vld & ~fifo_full;
  assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge i_uart_gck) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_uart_tx_data;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    unique case (tx_state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_head;
          tx_d       = 1'b0;
          tx_cnt_d   = BIT_LAST;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_d       = tx_shift_q[0];
          tx_bit_d   = 3'd0;
          tx_cnt_d   = BIT_LAST;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LAST;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == '0) begin
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            pop        = 1'b1;
            tx_shift_d = fifo_head;
            tx_d       = 1'b0;
            tx_cnt_d   = BIT_LAST;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

`ifdef IDLI_UART_LOOPBACK_EN
  logic unused_rx_pin;
  assign unused_rx_pin = i_uart_rx;
  assign rx_src        = tx_q;
`else
  assign rx_src = i_uart_rx;
`endif

  assign rx_s1_d = rx_src;
  assign rx_s2_d = rx_s1_q;
  assign rx_pop  = rx_vld_q & i_uart_rx_rdy;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_vld_d   = rx_pop ? 1'b0 : rx_vld_q;
    rx_ovf_d   = rx_ovf_q;
    rx_ferr_d  = rx_ferr_q;
    unique case (rx_state_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          rx_cnt_d   = HALF_LAST;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = BIT_LAST;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LAST;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = S_STOP;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = S_IDLE;
          if (!rx_s2_q) begin
            rx_ferr_d = 1'b1;
          end else if (!rx_vld_q || rx_pop) begin
            rx_data_d = rx_shift_q;
            rx_vld_d  = 1'b1;
          end else begin
            rx_ovf_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_uart_gck) begin
    if (i_uart_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_vld_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
      rx_ovf_q   <= rx_ovf_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign o_uart_tx      = tx_q;
  assign o_uart_tx_rdy  = ~fifo_full;
  assign o_uart_rx_data = rx_data_q;
  assign o_uart_rx_vld  = rx_vld_q;
  assign o_uart_rx_ovf  = rx_ovf_q;
  assign o_uart_rx_ferr = rx_ferr_q;

endmodule

// File: tb/tb_idli_uart_m.sv
// Directed testbench for idli_uart_m at CLKS_PER_BIT=4, TX_DEPTH=4.
// lb routes the TX pin back into the RX pin for round-trip traffic.
module tb_idli_uart_m;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_vld = 1'b0;
  logic       rx_rdy = 1'b0;
  logic       rx_drv = 1'b1;
  logic       lb = 1'b0;
  wire        tx_rdy, rx_vld, rx_ovf, rx_ferr, tx_pin, rx_pin;
  wire  [7:0] rx_data;

  int checks = 0;
  int errors = 0;

  logic rec_en = 1'b0;
  logic rec_q[$];

  assign rx_pin = lb ? tx_pin : rx_drv;

  always #5 clk = ~clk;

  always @(negedge clk) if (rec_en) rec_q.push_back(tx_pin);

  idli_uart_m #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
    .i_uart_gck    (clk),
    .i_uart_rst    (rst),
    .i_uart_tx_data(tx_data),
    .i_uart_tx_vld (tx_vld),
    .o_uart_tx_rdy (tx_rdy),
    .o_uart_rx_data(rx_data),
    .o_uart_rx_vld (rx_vld),
    .i_uart_rx_rdy (rx_rdy),
    .o_uart_rx_ovf (rx_ovf),
    .o_uart_rx_ferr(rx_ferr),
    .i_uart_rx     (rx_pin),
    .o_uart_tx     (tx_pin)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(input logic [7:0] b, input int idx);
    logic [7:0] v;
    v = b;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return v[idx-1];
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      rx_drv = (i == 9) ? stop : fbit(b, i);
      repeat (CPB) tick();
    end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b exp 1", tx_pin); end
    checks++; if (tx_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b exp 1", tx_rdy); end
    checks++; if (rx_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b exp 0", rx_vld); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", rx_data); end
    checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", rx_ovf); end
    checks++; if (rx_ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b exp 0", rx_ferr); end
  endtask

  task automatic test_tx_single();
    logic e;
    tx_data = 8'hA5;
    tx_vld  = 1'b1;
    tick();
    tx_vld = 1'b0;
    checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL tx_push_edge: got %b exp 1", tx_pin); end
    for (int i = 0; i < 40; i++) begin
      tick();
      e = fbit(8'hA5, i / 4);
      checks++;
      if (tx_pin !== e || tx_rdy !== 1'b1) begin
        errors++;
        $display("FAIL tx_single cyc %0d: tx %b rdy %b exp tx %b rdy 1", i, tx_pin, tx_rdy, e);
      end
    end
    tick();
    checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL tx_single_idle: got %b exp 1", tx_pin); end
  endtask

  task automatic test_tx_fill();
    int n, guard, fz;
    logic fire, e;
    logic [39:0] got, exp;
    rec_q.delete();
    rec_en = 1'b1;
    n = 0;
    guard = 0;
    while (n < 5 && guard < 20) begin
      tx_data = 8'(n + 1);
      tx_vld  = 1'b1;
      fire    = tx_rdy;
      tick();
      guard++;
      if (fire) n++;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL fill_push: pushed %0d exp 5", n); end
    checks++; if (tx_rdy !== 1'b0) begin errors++; $display("FAIL fill_full: rdy %b exp 0", tx_rdy); end
    tx_data = 8'h66;
    repeat (3) tick();
    tx_vld = 1'b0;
    checks++; if (tx_rdy !== 1'b0) begin errors++; $display("FAIL fill_held: rdy %b exp 0", tx_rdy); end
    repeat (5 * 40 + 10) tick();
    rec_en = 1'b0;
    checks++; if (tx_rdy !== 1'b1) begin errors++; $display("FAIL fill_drain: rdy %b exp 1", tx_rdy); end
    fz = -1;
    for (int i = 0; i < rec_q.size(); i++) begin
      if (fz < 0 && rec_q[i] === 1'b0) fz = i;
    end
    checks++; if (fz != 2) begin errors++; $display("FAIL fill_latency: first start at %0d exp 2", fz); end
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 40; j++) begin
        got[j] = rec_q[2 + 40 * k + j];
        exp[j] = fbit(8'(k + 1), j / 4);
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fill_frame%0d: got %h exp %h", k, got, exp);
      end
    end
    e = 1'b1;
    for (int i = 202; i < rec_q.size(); i++) if (rec_q[i] !== 1'b1) e = 1'b0;
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL fill_tail: line not idle after 5 frames, got %b exp 1", e); end
  endtask

  task automatic test_rx_byte();
    rx_rdy = 1'b0;
    send_rx(8'h3C, 1'b1);
    checks++; if (rx_vld !== 1'b0) begin errors++; $display("FAIL rx_early: vld %b exp 0", rx_vld); end
    tick();
    checks++; if (rx_vld !== 1'b1) begin errors++; $display("FAIL rx_vld: got %b exp 1", rx_vld); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rx_data: got %h exp 3c", rx_data); end
    checks++; if ({rx_ovf, rx_ferr} !== 2'b00) begin errors++; $display("FAIL rx_flags: got %b%b exp 00", rx_ovf, rx_ferr); end
  endtask

  task automatic test_rx_overrun();
    rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    checks++; if (rx_vld !== 1'b0) begin errors++; $display("FAIL pop_vld: got %b exp 0", rx_vld); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL pop_keep: got %h exp 3c", rx_data); end
    send_rx(8'h11, 1'b1);
    tick();
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovf_first: got %h exp 11", rx_data); end
    send_rx(8'h22, 1'b1);
    tick();
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovf_keep: got %h exp 11", rx_data); end
    checks++; if (rx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", rx_ovf); end
    checks++; if (rx_vld !== 1'b1) begin errors++; $display("FAIL ovf_vld: got %b exp 1", rx_vld); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", rx_ovf); end
    send_rx(8'h11, 1'b1);
    tick();
    send_rx(8'h22, 1'b1);
    rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL popcomp_data: got %h exp 22", rx_data); end
    checks++; if (rx_vld !== 1'b1) begin errors++; $display("FAIL popcomp_vld: got %b exp 1", rx_vld); end
    checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL popcomp_ovf: got %b exp 0", rx_ovf); end
  endtask

  task automatic test_rx_errors();
    rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    repeat (20) tick();
    checks++; if ({rx_vld, rx_ovf, rx_ferr} !== 3'b000) begin errors++; $display("FAIL glitch: vld/ovf/ferr %b%b%b exp 000", rx_vld, rx_ovf, rx_ferr); end
    send_rx(8'h55, 1'b0);
    tick();
    checks++; if (rx_ferr !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b exp 1", rx_ferr); end
    checks++; if (rx_vld !== 1'b0) begin errors++; $display("FAIL ferr_vld: got %b exp 0", rx_vld); end
    repeat (20) tick();
    checks++; if (rx_vld !== 1'b0 || rx_ferr !== 1'b1) begin errors++; $display("FAIL ferr_sticky: vld %b ferr %b exp 0 1", rx_vld, rx_ferr); end
  endtask

  task automatic test_reset_midframe();
    logic bad;
    int   wait_n;
    lb = 1'b1;
    tick();
    tx_data = 8'hC3;
    tx_vld  = 1'b1;
    tick();
    tx_data = 8'h99;
    tick();
    tx_vld = 1'b0;
    repeat (17) tick();
    checks++; if (tx_pin !== 1'b0) begin errors++; $display("FAIL mid_bit3: tx %b exp 0", tx_pin); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b exp 1", tx_pin); end
    checks++; if (tx_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy: got %b exp 1", tx_rdy); end
    checks++; if (rx_vld !== 1'b0) begin errors++; $display("FAIL mid_vld: got %b exp 0", rx_vld); end
    checks++; if (rx_ferr !== 1'b0) begin errors++; $display("FAIL mid_ferr: got %b exp 0", rx_ferr); end
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_pin !== 1'b1 || rx_vld !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mid_discard: activity %b exp 0", bad); end
    tx_data = 8'h7E;
    tx_vld  = 1'b1;
    tick();
    tx_vld = 1'b0;
    wait_n = 0;
    while (rx_vld !== 1'b1 && wait_n < 100) begin
      tick();
      wait_n++;
    end
    checks++; if (rx_vld !== 1'b1) begin errors++; $display("FAIL loop_timeout: vld %b exp 1", rx_vld); end
    checks++; if (rx_data !== 8'h7E) begin errors++; $display("FAIL loop_data: got %h exp 7e", rx_data); end
    checks++; if ({rx_ovf, rx_ferr} !== 2'b00) begin errors++; $display("FAIL loop_flags: got %b%b exp 00", rx_ovf, rx_ferr); end
    lb = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_tx_single();
    test_tx_fill();
`ifndef IDLI_UART_LOOPBACK_EN
    test_rx_byte();
    test_rx_overrun();
    test_rx_errors();
`endif
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
